seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver_if.sv | 31 +++
 rtl/seg_scan_driver.sv | 194 +++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// seg_scan_driver_if
// Groups the value/handshake and display signals of seg_scan_driver.
//   bin_in      : 14-bit unsigned value to convert (host -> driver)
//   load        : single-cycle convert request     (host -> driver)
//   blank_lz    : blank leading-zero digits        (host -> driver)
//   busy        : conversion in progress           (driver -> host)
//   ovf         : last accepted value was clamped  (driver -> host)
//   digit_value : BCD nibble of the selected digit (driver -> display)
//   anode_n     : active-low digit enables         (driver -> display)
// Modports: master = host/bench side, slave = driver side.
// ---------------------------------------------------------------------------
interface seg_scan_driver_if;
  logic [13:0] bin_in;
  logic        load;
  logic        blank_lz;
  logic        busy;
  logic        ovf;
  logic [3:0]  digit_value;
  logic [3:0]  anode_n;

  modport master (
    output bin_in, load, blank_lz,
    input  busy, ovf, digit_value, anode_n
  );

  modport slave (
    input  bin_in, load, blank_lz,
    output busy, ovf, digit_value, anode_n
  );
endinterface

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Converts a 14-bit binary value (clamped to 9999) to four BCD digits with a
// serial double-dabble engine (one iteration per clock, 14 iterations), then
// multiplexes the digits onto a common-anode 4-digit 7-segment display.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg_scan_driver_if.slave (bin_in, load, blank_lz in;
//           busy, ovf, digit_value, anode_n out)
// Parameter:
//   REFRESH_DIV : clk cycles each digit stays selected (2..2^20)
// ---------------------------------------------------------------------------
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

  localparam logic [19:0] PRESC_MAX  = 20'(REFRESH_DIV - 32'd1);
  localparam logic [13:0] CLAMP_MAX  = 14'd9999;
  localparam logic [3:0]  LAST_ITER  = 4'd13;

  // One double-dabble step: add 3 to every nibble >= 5, then shift in msb.
  function automatic logic [15:0] dd_step(input logic [15:0] bcd, input logic msb);
    logic [15:0] adj;
    adj = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end else begin
        adj[n*4 +: 4] = bcd[n*4 +: 4];
      end
    end
    return {adj[14:0], msb};
  endfunction

  state_t      state_r, state_s;
  logic [13:0] bin_r,   bin_s;
  logic [15:0] bcd_r,   bcd_s;
  logic [3:0]  iter_r,  iter_s;
  logic        busy_r,  busy_s;
  logic        ovf_r,   ovf_s;
  logic [15:0] disp_r,  disp_s;
  logic [15:0] bcd_step_s;

  logic [19:0] presc_r, presc_s;
  logic [1:0]  idx_r,   idx_s;
  logic        wrap_s;
  logic        blank_s;
  logic [3:0]  digit_sel_s;
  logic [3:0]  anode_sel_s;
  logic [3:0]  digit_value_r;
  logic [3:0]  anode_n_r;

  assign bcd_step_s = dd_step(bcd_r, bin_r[13]);

  // Conversion FSM: next state, datapath and display-commit decisions.
  always_comb begin
    state_s = state_r;
    bin_s   = bin_r;
    bcd_s   = bcd_r;
    iter_s  = iter_r;
    busy_s  = busy_r;
    ovf_s   = ovf_r;
    disp_s  = disp_r;
    case (state_r)
      IDLE: begin
        if (bus.load) begin
          state_s = CONVERT;
          busy_s  = 1'b1;
          iter_s  = 4'd0;
          bcd_s   = 16'h0000;
          if (bus.bin_in > CLAMP_MAX) begin
            bin_s = CLAMP_MAX;
            ovf_s = 1'b1;
          end else begin
            bin_s = bus.bin_in;
            ovf_s = 1'b0;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      CONVERT: begin
        bcd_s = bcd_step_s;
        bin_s = {bin_r[12:0], 1'b0};
        if (iter_r == LAST_ITER) begin
          // Final iteration result goes straight to the display in one edge.
          disp_s  = bcd_step_s;
          state_s = IDLE;
          busy_s  = 1'b0;
          iter_s  = 4'd0;
        end else begin
          iter_s = iter_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        iter_s  = 4'd0;
      end
    endcase
  end

  // Conversion FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      bin_r   <= 14'd0;
      bcd_r   <= 16'h0000;
      iter_r  <= 4'd0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
      disp_r  <= 16'h0000;
    end else begin
      state_r <= state_s;
      bin_r   <= bin_s;
      bcd_r   <= bcd_s;
      iter_r  <= iter_s;
      busy_r  <= busy_s;
      ovf_r   <= ovf_s;
      disp_r  <= disp_s;
    end
  end

  // Scan prescaler/index next values and the slot's digit/anode selection.
  // Selection uses the next index so outputs move on the same edge as it.
  always_comb begin
    wrap_s  = (presc_r == PRESC_MAX);
    presc_s = wrap_s ? 20'd0 : (presc_r + 20'd1);
    idx_s   = wrap_s ? (idx_r + 2'd1) : idx_r;
    blank_s = 1'b0;
    case (idx_s)
      2'd0: begin
        digit_sel_s = disp_r[3:0];
        anode_sel_s = 4'b1110;
      end
      2'd1: begin
        digit_sel_s = disp_r[7:4];
        anode_sel_s = 4'b1101;
        blank_s     = (disp_r[15:4] == 12'h000);
      end
      2'd2: begin
        digit_sel_s = disp_r[11:8];
        anode_sel_s = 4'b1011;
        blank_s     = (disp_r[15:8] == 8'h00);
      end
      2'd3: begin
        digit_sel_s = disp_r[15:12];
        anode_sel_s = 4'b0111;
        blank_s     = (disp_r[15:12] == 4'h0);
      end
      default: begin
        digit_sel_s = disp_r[3:0];
        anode_sel_s = 4'b1110;
      end
    endcase
    // Digit 0 is never blanked (its slot has blank_s = 0 above).
    if (bus.blank_lz && blank_s) begin
      anode_sel_s = 4'b1111;
    end else begin
      anode_sel_s = anode_sel_s;
    end
  end

  // Scan prescaler, digit index and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= 20'd0;
      idx_r         <= 2'd0;
      digit_value_r <= 4'h0;
      anode_n_r     <= 4'b1110;
    end else begin
      presc_r       <= presc_s;
      idx_r         <= idx_s;
      digit_value_r <= digit_sel_s;
      anode_n_r     <= anode_sel_s;
    end
  end

  assign bus.busy        = busy_r;
  assign bus.ovf         = ovf_r;
  assign bus.digit_value = digit_value_r;
  assign bus.anode_n     = anode_n_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with REFRESH_DIV = 4. Expected digit and
// anode patterns are hand-computed; the scan slot is derived from the number
// of clock edges since reset release (slot changes every 4 edges).
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  seg_scan_driver_if bus_if ();

  seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; slot = (cyc / 4) % 4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe 16 cycles (all four slots) against expected digits and blank mask.
  task automatic check_display(input string tag, input logic [15:0] digs, input logic [3:0] blank_mask);
    int slot;
    logic [3:0] exp_anode;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      slot = (cyc / 4) % 4;
      exp_anode = blank_mask[slot] ? 4'b1111 : ~(4'b0001 << slot);
      check({tag, "_anode"}, {12'h000, bus_if.anode_n}, {12'h000, exp_anode});
      check({tag, "_digit"}, {12'h000, bus_if.digit_value}, {12'h000, digs[slot*4 +: 4]});
    end
  endtask

  // Must be called at a negedge: load is sampled on the very next edge.
  task automatic do_load(input logic [13:0] v, input logic exp_ovf);
    bus_if.bin_in = v;
    bus_if.load   = 1'b1;
    @(negedge clk);
    bus_if.load   = 1'b0;
    for (int i = 0; i < 14; i++) begin
      check("busy_high", {15'h0000, bus_if.busy}, 16'h0001);
      @(negedge clk);
    end
    check("busy_low", {15'h0000, bus_if.busy}, 16'h0000);
    check("ovf", {15'h0000, bus_if.ovf}, {15'h0000, exp_ovf});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus_if.bin_in   = 14'd0;
    bus_if.load     = 1'b0;
    bus_if.blank_lz = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_anode", {12'h000, bus_if.anode_n}, 16'h000E);
    check("rst_digit", {12'h000, bus_if.digit_value}, 16'h0000);
    check("rst_busy", {15'h0000, bus_if.busy}, 16'h0000);
    check("rst_ovf", {15'h0000, bus_if.ovf}, 16'h0000);
    rst_n = 1'b1;

    // Free-running scan of an all-zero display.
    check_display("scan0", 16'h0000, 4'b0000);

    // Plain conversion.
    do_load(14'd1234, 1'b0);
    check_display("d1234", 16'h1234, 4'b0000);

    // Clamp and overflow, then overflow cleared by the next load.
    do_load(14'd12000, 1'b1);
    check_display("d9999", 16'h9999, 4'b0000);
    do_load(14'd5, 1'b0);
    check_display("d0005", 16'h0005, 4'b0000);

    // Leading-zero blanking.
    bus_if.blank_lz = 1'b1;
    do_load(14'd40, 1'b0);
    check_display("blank40", 16'h0040, 4'b1100);
    do_load(14'd0, 1'b0);
    check_display("blank0", 16'h0000, 4'b1110);
    bus_if.blank_lz = 1'b0;

    // Loads while busy (cycle 7 and final cycle) are ignored.
    bus_if.bin_in = 14'd1234;
    bus_if.load   = 1'b1;
    @(negedge clk);
    bus_if.load   = 1'b0;
    bus_if.bin_in = 14'd5678;
    for (int i = 0; i < 14; i++) begin
      check("ign_busy", {15'h0000, bus_if.busy}, 16'h0001);
      bus_if.load = (i == 6 || i == 13);
      @(negedge clk);
    end
    bus_if.load = 1'b0;
    check("ign_busy_low", {15'h0000, bus_if.busy}, 16'h0000);
    check_display("ign1234", 16'h1234, 4'b0000);

    // Load in the first idle cycle after busy falls is accepted.
    do_load(14'd99, 1'b0);
    do_load(14'd5678, 1'b0);
    check_display("d5678", 16'h5678, 4'b0000);

    // Reset during conversion cycle 9 aborts without commit.
    bus_if.bin_in = 14'd4321;
    bus_if.load   = 1'b1;
    @(negedge clk);
    bus_if.load   = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_busy_pre", {15'h0000, bus_if.busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {15'h0000, bus_if.busy}, 16'h0000);
    check("mid_rst_anode", {12'h000, bus_if.anode_n}, 16'h000E);
    check("mid_rst_digit", {12'h000, bus_if.digit_value}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", {15'h0000, bus_if.busy}, 16'h0000);
    check_display("post_rst", 16'h0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
